// File: rtl/acm_bank_if.sv
// acm_bank_if: sample/result bundle for the acm_bank accumulator bank.
//   master (sample source side): drives x, ch, op, in_valid, clear;
//                                observes s, s_ch, out_valid, ovf.
//   slave  (acm_bank side):      the mirror image.
//   x         WIDTH     unsigned sample
//   ch        CH_W      target channel
//   op        1         0 = add, 1 = subtract
//   in_valid  1         sample accepted this cycle
//   clear     1         synchronous clear of all sums and flags
//   s         WIDTH     updated sum of the last accepted channel
//   s_ch      CH_W      channel that s belongs to
//   out_valid 1         s/s_ch are fresh this cycle
//   ovf       CHANNELS  sticky per-channel overflow/underflow flags
interface acm_bank_if #(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 4,
    parameter int CH_W     = $clog2(CHANNELS)
);
    logic [WIDTH-1:0]    x;
    logic [CH_W-1:0]     ch;
    logic                op;
    logic                in_valid;
    logic                clear;
    logic [WIDTH-1:0]    s;
    logic [CH_W-1:0]     s_ch;
    logic                out_valid;
    logic [CHANNELS-1:0] ovf;

    modport master (
        output x, ch, op, in_valid, clear,
        input  s, s_ch, out_valid, ovf
    );

    modport slave (
        input  x, ch, op, in_valid, clear,
        output s, s_ch, out_valid, ovf
    );
endinterface

// File: rtl/acm_bank.sv
// acm_bank: CHANNELS independent unsigned WIDTH-bit running sums.
// Each accepted sample adds to or subtracts from the selected channel;
// the updated sum appears on s/s_ch one cycle later with out_valid.
// Carry/borrow set a sticky per-channel ovf bit.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    acm_bank_if.slave (x, ch, op, in_valid, clear -> s, s_ch,
//          out_valid, ovf)
// Configuration macro: ACM_SATURATE_EN
//   defined   -> results clamp to 2^WIDTH-1 on overflow, 0 on underflow
//   undefined -> results wrap modulo 2^WIDTH
module acm_bank #(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 4,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic       clock,
    input  logic       reset,
    acm_bank_if.slave  bus
);

    logic [WIDTH-1:0] acc [CHANNELS];

    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   sum;
    logic             flag;
    logic [WIDTH-1:0] wr;

    // The addressed sum is read combinationally from the register array and
    // written back on the same edge, so back-to-back samples to one channel
    // always see the previous update without any stall.
    always_comb begin
        cur = acc[bus.ch];
        if (bus.op) begin
            sum = {1'b0, cur} - {1'b0, bus.x};
        end else begin
            sum = {1'b0, cur} + {1'b0, bus.x};
        end
        // The extra bit is the carry for add and the borrow for subtract.
        flag = sum[WIDTH];
`ifdef ACM_SATURATE_EN
        if (flag) begin
            wr = bus.op ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end else begin
            wr = sum[WIDTH-1:0];
        end
`else
        wr = sum[WIDTH-1:0];
`endif
    end

    // NOTE: the accumulator array is reset here because every sum must read
    // as zero immediately on reset; it is a small register file, not a RAM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            bus.ovf       <= '0;
            bus.s         <= '0;
            bus.s_ch      <= '0;
            bus.out_valid <= 1'b0;
        end else if (bus.clear) begin
            // clear wins over in_valid; s/s_ch keep their last values.
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            bus.ovf       <= '0;
            bus.out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            acc[bus.ch]     <= wr;
            bus.ovf[bus.ch] <= bus.ovf[bus.ch] | flag;
            bus.s           <= wr;
            bus.s_ch        <= bus.ch;
            bus.out_valid   <= 1'b1;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
